// File: rtl/hazard_ctrl_pipe.sv
// Hazard control for a 5-stage in-order pipeline: load-use stall, taken-branch flush,
// EX operand forwarding select and the ID/EX, EX/MEM, MEM/WB control registers.
module hazard_ctrl_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_alu_src,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        id_branch,
    input  logic [1:0]  id_alu_op,
    input  logic        ex_branch_taken,
    output logic        stall,
    output logic        flush,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_alu_src,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        ex_branch,
    output logic [1:0]  ex_alu_op,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic        mem_reg_write,
    output logic        mem_mem_write,
    output logic        mem_mem_to_reg,
    output logic [4:0]  mem_rd,
    output logic        wb_reg_write,
    output logic        wb_mem_to_reg,
    output logic [4:0]  wb_rd,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] bubble_count
);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic [1:0] alu_op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } id_ex_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    id_ex_t      id_ex_q;
    id_ex_t      id_ex_d;
    logic        load_use;
    logic        rs1_dep;
    logic        rs2_dep;
    logic        branch_flush;
    logic        bubble;
    logic        mem_reg_write_q;
    logic        mem_mem_write_q;
    logic        mem_mem_to_reg_q;
    logic [4:0]  mem_rd_q;
    logic        wb_reg_write_q;
    logic        wb_mem_to_reg_q;
    logic [4:0]  wb_rd_q;
    logic [15:0] bubble_cnt_q;

    // rs2 is only a real source when it feeds the ALU or supplies store data.
    always_comb begin
        rs1_dep  = (id_ex_q.rd == id_rs1);
        rs2_dep  = (id_ex_q.rd == id_rs2) && (!id_alu_src || id_mem_write);
        load_use = id_valid && id_ex_q.valid && id_ex_q.mem_to_reg &&
                   (id_ex_q.rd != 5'd0) && (rs1_dep || rs2_dep);
    end

    // A flush already kills the ID instruction, so it wins over a stall.
    always_comb begin
        branch_flush = id_ex_q.valid && id_ex_q.branch && ex_branch_taken;
        stall        = load_use && !branch_flush;
        flush        = branch_flush;
        bubble       = stall || flush;
    end

    always_comb begin
        id_ex_d = '0;
        if (!bubble) begin
            id_ex_d.valid      = id_valid;
            id_ex_d.reg_write  = id_reg_write;
            id_ex_d.alu_src    = id_alu_src;
            id_ex_d.mem_write  = id_mem_write;
            id_ex_d.mem_to_reg = id_mem_to_reg;
            id_ex_d.branch     = id_branch;
            id_ex_d.alu_op     = id_alu_op;
            id_ex_d.rs1        = id_rs1;
            id_ex_d.rs2        = id_rs2;
            id_ex_d.rd         = id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    // Invalid EX slots must not leave a write intent behind in later stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg_write_q  <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_mem_to_reg_q <= 1'b0;
            mem_rd_q         <= 5'd0;
        end else begin
            mem_reg_write_q  <= id_ex_q.reg_write  & id_ex_q.valid;
            mem_mem_write_q  <= id_ex_q.mem_write  & id_ex_q.valid;
            mem_mem_to_reg_q <= id_ex_q.mem_to_reg & id_ex_q.valid;
            mem_rd_q         <= id_ex_q.rd & {5{id_ex_q.valid}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rd_q         <= 5'd0;
        end else begin
            wb_reg_write_q  <= mem_reg_write_q;
            wb_mem_to_reg_q <= mem_mem_to_reg_q;
            wb_rd_q         <= mem_rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'd0;
        end else if (bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    // A load in MEM has no data yet, so it never forwards from that stage.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_reg_write_q && !mem_mem_to_reg_q && (mem_rd_q != 5'd0) &&
            (mem_rd_q == id_ex_q.rs1)) begin
            fwd_a = FWD_MEM;
        end else if (wb_reg_write_q && (wb_rd_q != 5'd0) && (wb_rd_q == id_ex_q.rs1)) begin
            fwd_a = FWD_WB;
        end
        if (mem_reg_write_q && !mem_mem_to_reg_q && (mem_rd_q != 5'd0) &&
            (mem_rd_q == id_ex_q.rs2)) begin
            fwd_b = FWD_MEM;
        end else if (wb_reg_write_q && (wb_rd_q != 5'd0) && (wb_rd_q == id_ex_q.rs2)) begin
            fwd_b = FWD_WB;
        end
    end

    always_comb begin
        ex_valid       = id_ex_q.valid;
        ex_reg_write   = id_ex_q.reg_write;
        ex_alu_src     = id_ex_q.alu_src;
        ex_mem_write   = id_ex_q.mem_write;
        ex_mem_to_reg  = id_ex_q.mem_to_reg;
        ex_branch      = id_ex_q.branch;
        ex_alu_op      = id_ex_q.alu_op;
        ex_rs1         = id_ex_q.rs1;
        ex_rs2         = id_ex_q.rs2;
        ex_rd          = id_ex_q.rd;
        mem_reg_write  = mem_reg_write_q;
        mem_mem_write  = mem_mem_write_q;
        mem_mem_to_reg = mem_mem_to_reg_q;
        mem_rd         = mem_rd_q;
        wb_reg_write   = wb_reg_write_q;
        wb_mem_to_reg  = wb_mem_to_reg_q;
        wb_rd          = wb_rd_q;
        bubble_count   = bubble_cnt_q;
    end

endmodule
